// File: rtl/edge_evt_pkg.sv
// edge_evt_pkg: shared mode constants and arbiter FSM state encoding
package edge_evt_pkg;
  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;
  typedef enum logic {ST_IDLE, ST_OFFER} state_t;
endpackage

// File: rtl/edge_chan.sv
// edge_chan: one channel edge detector with pending/etype hold (overflow flag when EDGE_EVT_OVERFLOW_EN)
module edge_chan
  import edge_evt_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       d,
  input  logic [1:0] mode,
  input  logic       grant_clr,
  output logic       pending,
  output logic       etype
`ifdef EDGE_EVT_OVERFLOW_EN
  ,
  input  logic       ovf_clr,
  output logic       overflow
`endif
);
  logic prev;
  logic edge_det;
  logic qual;
  logic kill;
  // qualify the edge against the mode; an edge while off discards the pending event
  always_comb begin
    edge_det = d != prev;
    qual = edge_det && (d ? (mode == MODE_RISE || mode == MODE_BOTH) : (mode == MODE_FALL || mode == MODE_BOTH));
    kill = edge_det && mode == MODE_OFF;
  end
  // a new qualified edge beats a same-cycle grant clear
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= 1'b0;
      pending <= 1'b0;
      etype <= 1'b0;
    end else begin
      prev <= d;
      pending <= qual || (pending && !grant_clr && !kill);
      if (qual) etype <= d;
    end
  end
`ifdef EDGE_EVT_OVERFLOW_EN
  // sticky lost-event flag; a new loss beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) overflow <= 1'b0;
    else overflow <= (qual && pending && !grant_clr) || (overflow && !ovf_clr);
  end
`endif
endmodule

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: N-channel edge detector with round-robin valid/ready event output (optional EDGE_EVT_OVERFLOW_EN)
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int N = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   data_in,
  input  logic [2*N-1:0] mode,
  output logic           evt_valid,
  input  logic           evt_ready,
  output logic [IDW-1:0] evt_id,
  output logic           evt_edge,
  output logic [N-1:0]   pending
`ifdef EDGE_EVT_OVERFLOW_EN
  ,
  output logic [N-1:0]   overflow,
  input  logic [N-1:0]   ovf_clr
`endif
);
  state_t state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] nxt_ptr;
  logic [IDW-1:0] base;
  logic [IDW-1:0] idx;
  logic [IDW-1:0] sel;
  logic [N-1:0] etype;
  logic [N-1:0] grant;
  logic found;
  logic load;
  for (genvar i = 0; i < N; i++) begin : g_chan
    edge_chan u_chan (
      .clk(clk),
      .rst(rst),
      .d(data_in[i]),
      .mode(mode[2*i +: 2]),
      .grant_clr(grant[i]),
      .pending(pending[i]),
      .etype(etype[i])
`ifdef EDGE_EVT_OVERFLOW_EN
      ,
      .ovf_clr(ovf_clr[i]),
      .overflow(overflow[i])
`endif
    );
  end
  // round-robin pick: first pending channel at or after the search base, wrapping
  always_comb begin
    nxt_ptr = (evt_id == IDW'(N - 1)) ? '0 : evt_id + IDW'(1);
    base = (state == ST_OFFER) ? nxt_ptr : ptr;
    idx = '0;
    sel = '0;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IDW'((int'(base) + k) % N);
      if (pending[idx]) begin
        sel = idx;
        found = 1'b1;
      end
    end
    load = found && (state == ST_IDLE || evt_ready);
    grant = load ? (N'(1) << sel) : '0;
  end
  // offer FSM: load in IDLE or on acceptance, hold while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ptr <= '0;
      evt_valid <= 1'b0;
      evt_id <= '0;
      evt_edge <= 1'b0;
    end else begin
      if (state == ST_OFFER && evt_ready) ptr <= nxt_ptr;
      if (load) begin
        evt_id <= sel;
        evt_edge <= etype[sel];
      end
      evt_valid <= load || (state == ST_OFFER && !evt_ready);
      state <= (load || (state == ST_OFFER && !evt_ready)) ? ST_OFFER : ST_IDLE;
    end
  end
endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: directed scenarios plus randomized run against a behavioural model
module tb_edge_event_arbiter;
  localparam int N = 4;
  logic clk = 0;
  logic rst = 1;
  logic [N-1:0] data_in = '0;
  logic [2*N-1:0] mode = '0;
  logic evt_ready = 0;
  logic evt_valid;
  logic [1:0] evt_id;
  logic evt_edge;
  logic [N-1:0] pending;
  logic [N-1:0] ovf_clr = '0;
`ifdef EDGE_EVT_OVERFLOW_EN
  logic [N-1:0] overflow;
`endif
  int n_chk = 0;
  int n_fail = 0;

  bit m_prev [N];
  bit m_pend [N];
  bit m_et [N];
  bit m_valid;
  int m_id;
  bit m_edge;
  int m_ptr;

  edge_event_arbiter #(.N(N)) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .mode(mode),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_id(evt_id),
    .evt_edge(evt_edge),
    .pending(pending)
`ifdef EDGE_EVT_OVERFLOW_EN
    ,
    .overflow(overflow),
    .ovf_clr(ovf_clr)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    data_in = '0;
    ovf_clr = '0;
    evt_ready = 0;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", evt_valid); end
    n_chk++; if (pending !== 4'b0) begin n_fail++; $display("FAIL reset_pending got=%b exp=0000", pending); end
    n_chk++; if (evt_id !== 2'd0 || evt_edge !== 1'b0) begin n_fail++; $display("FAIL reset_id_edge got=%0d/%b exp=0/0", evt_id, evt_edge); end
  endtask

  task automatic test_single();
    do_reset();
    mode = 8'b01010101;
    evt_ready = 1;
    data_in = 4'b0100;
    tick();
    n_chk++; if (pending !== 4'b0100 || evt_valid !== 1'b0) begin n_fail++; $display("FAIL single_pend got=%b/%b exp=0100/0", pending, evt_valid); end
    tick();
    n_chk++; if (evt_valid !== 1'b1 || evt_id !== 2'd2 || evt_edge !== 1'b1) begin n_fail++; $display("FAIL single_evt got=%b id=%0d e=%b exp=1 id=2 e=1", evt_valid, evt_id, evt_edge); end
    n_chk++; if (pending !== 4'b0) begin n_fail++; $display("FAIL single_cleared got=%b exp=0000", pending); end
    tick();
    n_chk++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL single_drop got=%b exp=0", evt_valid); end
  endtask

  task automatic test_back_to_back();
    int exp_id [3] = '{0, 1, 3};
    do_reset();
    mode = 8'hFF;
    evt_ready = 1;
    data_in = 4'b1011;
    tick();
    n_chk++; if (pending !== 4'b1011) begin n_fail++; $display("FAIL b2b_pend got=%b exp=1011", pending); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++; if (evt_valid !== 1'b1 || int'(evt_id) != exp_id[k] || evt_edge !== 1'b1) begin n_fail++; $display("FAIL b2b_evt%0d got=%b id=%0d exp=1 id=%0d", k, evt_valid, evt_id, exp_id[k]); end
    end
    tick();
    n_chk++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end got=%b exp=0", evt_valid); end
  endtask

  task automatic test_falling_only();
    do_reset();
    mode = 8'b00001000;
    evt_ready = 1;
    data_in = 4'b0010;
    tick();
    tick();
    n_chk++; if (evt_valid !== 1'b0 || pending !== 4'b0) begin n_fail++; $display("FAIL fall_rise_ignored got=%b/%b exp=0/0000", evt_valid, pending); end
    data_in = 4'b0000;
    tick();
    tick();
    n_chk++; if (evt_valid !== 1'b1 || evt_id !== 2'd1 || evt_edge !== 1'b0) begin n_fail++; $display("FAIL fall_evt got=%b id=%0d e=%b exp=1 id=1 e=0", evt_valid, evt_id, evt_edge); end
    tick();
    n_chk++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL fall_single got=%b exp=0", evt_valid); end
  endtask

  task automatic test_hold_fairness();
    int bad = 0;
    do_reset();
    mode = 8'hFF;
    data_in = 4'b0101;
    tick();
    tick();
    for (int k = 0; k < 10; k++) begin
      if (evt_valid !== 1'b1 || evt_id !== 2'd0 || evt_edge !== 1'b1) bad++;
      tick();
    end
    n_chk++; if (bad != 0 || evt_valid !== 1'b1 || evt_id !== 2'd0) begin n_fail++; $display("FAIL hold_stable unstable_cycles=%0d id=%0d exp=0 unstable, id=0", bad, evt_id); end
    evt_ready = 1;
    tick();
    n_chk++; if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin n_fail++; $display("FAIL hold_next got=%b id=%0d exp=1 id=2", evt_valid, evt_id); end
    evt_ready = 0;
    data_in = 4'b1100;
    tick();
    n_chk++; if (pending !== 4'b1001 || evt_id !== 2'd2) begin n_fail++; $display("FAIL hold_newpend got=%b id=%0d exp=1001 id=2", pending, evt_id); end
    evt_ready = 1;
    tick();
    n_chk++; if (evt_valid !== 1'b1 || evt_id !== 2'd3 || evt_edge !== 1'b1) begin n_fail++; $display("FAIL fair_ptr3 got=%b id=%0d e=%b exp=1 id=3 e=1", evt_valid, evt_id, evt_edge); end
    tick();
    n_chk++; if (evt_valid !== 1'b1 || evt_id !== 2'd0 || evt_edge !== 1'b0) begin n_fail++; $display("FAIL fair_ch0 got=%b id=%0d e=%b exp=1 id=0 e=0", evt_valid, evt_id, evt_edge); end
    tick();
    n_chk++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL fair_end got=%b exp=0", evt_valid); end
  endtask

  task automatic test_overwrite();
    do_reset();
    mode = 8'hFF;
    data_in = 4'b0001;
    tick();
    tick();
    data_in = 4'b1001;
    tick();
    data_in = 4'b0001;
    tick();
    n_chk++; if (pending !== 4'b1000 || evt_id !== 2'd0) begin n_fail++; $display("FAIL ovw_pend got=%b id=%0d exp=1000 id=0", pending, evt_id); end
`ifdef EDGE_EVT_OVERFLOW_EN
    n_chk++; if (overflow !== 4'b1000) begin n_fail++; $display("FAIL ovf_set got=%b exp=1000", overflow); end
    ovf_clr = 4'b1000;
    tick();
    ovf_clr = '0;
    n_chk++; if (overflow !== 4'b0000) begin n_fail++; $display("FAIL ovf_clr got=%b exp=0000", overflow); end
`endif
    evt_ready = 1;
    tick();
    n_chk++; if (evt_valid !== 1'b1 || evt_id !== 2'd3 || evt_edge !== 1'b0) begin n_fail++; $display("FAIL ovw_evt got=%b id=%0d e=%b exp=1 id=3 e=0", evt_valid, evt_id, evt_edge); end
    tick();
    n_chk++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL ovw_single got=%b exp=0", evt_valid); end
  endtask

  task automatic test_reset_mid_offer();
    do_reset();
    mode = 8'hFF;
    data_in = 4'b0010;
    tick();
    tick();
    n_chk++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL rmo_offer got=%b exp=1", evt_valid); end
    rst = 1;
    tick();
    n_chk++; if (evt_valid !== 1'b0 || pending !== 4'b0) begin n_fail++; $display("FAIL rmo_cleared got=%b/%b exp=0/0000", evt_valid, pending); end
    rst = 0;
    tick();
    n_chk++; if (pending !== 4'b0010) begin n_fail++; $display("FAIL rmo_highline got=%b exp=0010", pending); end
    tick();
    n_chk++; if (evt_valid !== 1'b1 || evt_id !== 2'd1 || evt_edge !== 1'b1) begin n_fail++; $display("FAIL rmo_evt got=%b id=%0d e=%b exp=1 id=1 e=1", evt_valid, evt_id, evt_edge); end
    evt_ready = 1;
    tick();
    tick();
    n_chk++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL rmo_once got=%b exp=0", evt_valid); end
  endtask

  task automatic model_step();
    int start;
    int sel;
    int c;
    bit e;
    bit q;
    logic [1:0] md;
    if (rst) begin
      foreach (m_pend[i]) begin m_prev[i] = 0; m_pend[i] = 0; m_et[i] = 0; end
      m_valid = 0; m_id = 0; m_edge = 0; m_ptr = 0;
      return;
    end
    start = m_valid ? (m_id + 1) % N : m_ptr;
    sel = -1;
    for (int k = 0; k < N; k++) begin
      c = (start + k) % N;
      if (m_pend[c] && sel < 0) sel = c;
    end
    if (m_valid && evt_ready) m_ptr = (m_id + 1) % N;
    if ((!m_valid || evt_ready) && sel >= 0) begin
      m_valid = 1; m_id = sel; m_edge = m_et[sel];
    end else begin
      m_valid = m_valid && !evt_ready;
      sel = -1;
    end
    for (int i = 0; i < N; i++) begin
      e = data_in[i] != m_prev[i];
      md = mode[2*i +: 2];
      q = e && (data_in[i] ? md[0] : md[1]);
      if (q) begin m_pend[i] = 1; m_et[i] = data_in[i]; end
      else if (i == sel || (e && md == 2'b00)) m_pend[i] = 0;
      m_prev[i] = data_in[i];
    end
  endtask

  task automatic test_random();
    logic [N-1:0] mp;
    rst = 1;
    model_step();
    tick();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) mode = 8'($urandom);
      data_in = data_in ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      evt_ready = ($urandom_range(0, 3) != 0);
      model_step();
      tick();
      foreach (m_pend[i]) mp[i] = m_pend[i];
      n_chk++; if (evt_valid !== m_valid || pending !== mp) begin n_fail++; $display("FAIL rand_state cyc=%0d got v=%b p=%b exp v=%b p=%b", cyc, evt_valid, pending, m_valid, mp); end
      if (m_valid) begin
        n_chk++; if (int'(evt_id) != m_id || evt_edge !== m_edge) begin n_fail++; $display("FAIL rand_evt cyc=%0d got id=%0d e=%b exp id=%0d e=%b", cyc, evt_id, evt_edge, m_id, m_edge); end
      end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_falling_only();
    test_hold_fairness();
    test_overwrite();
    test_reset_mid_offer();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
